transposed_folded_fir_hls_div_27s_11s_16_seq: RTL and testbench

Sequential signed divider. It undoes the tap-product scaling of the folded FIR datapath: it divides a 27-bit signed accumulator/product word by an 11-bit signed coefficient and returns a 16-bit signed quotient and an 11-bit signed remainder. It is used in the filterbank gain-normalisation and self-check paths. The multiplier there is a single-cycle combinational operator; this block is its iterative inverse, built as a radix-2 restoring divider behind valid/ready handshakes on both sides.

---
 rtl/transposed_folded_fir_hls_div_27s_11s_16_seq_if.sv | 33 +++
 rtl/transposed_folded_fir_hls_div_27s_11s_16_seq.sv | 147 ++++++++++++++
 tb/tb_transposed_folded_fir_hls_div_27s_11s_16_seq.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/transposed_folded_fir_hls_div_27s_11s_16_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : transposed_folded_fir_hls_div_27s_11s_16_seq_if
// Purpose  : Operand/result handshake bundle for the sequential signed divider.
// Revision : 1.0 - initial release
// ============================================================================
interface transposed_folded_fir_hls_div_27s_11s_16_seq_if #(
    parameter int DIVIDEND_WIDTH = 27,
    parameter int DIVISOR_WIDTH  = 11,
    parameter int QUOTIENT_WIDTH = 16
) ();
    logic signed [DIVIDEND_WIDTH-1:0] din0;
    logic signed [DIVISOR_WIDTH-1:0]  din1;
    logic                             in_valid;
    logic                             in_ready;
    logic signed [QUOTIENT_WIDTH-1:0] dout;
    logic signed [DIVISOR_WIDTH-1:0]  rem;
    logic                             out_valid;
    logic                             out_ready;
    logic                             ovf;
    logic                             div_by_zero;

    modport master (
        output din0, din1, in_valid, out_ready,
        input  in_ready, dout, rem, out_valid, ovf, div_by_zero
    );

    modport slave (
        input  din0, din1, in_valid, out_ready,
        output in_ready, dout, rem, out_valid, ovf, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/transposed_folded_fir_hls_div_27s_11s_16_seq.sv
`default_nettype none
// ============================================================================
// Module   : transposed_folded_fir_hls_div_27s_11s_16_seq
// Purpose  : Radix-2 restoring signed divider, saturating 16-bit quotient.
// Revision : 1.0 - initial release
// ============================================================================
module transposed_folded_fir_hls_div_27s_11s_16_seq #(
    parameter int DIVIDEND_WIDTH = 27,
    parameter int DIVISOR_WIDTH  = 11,
    parameter int QUOTIENT_WIDTH = 16
) (
    input  wire logic ap_clk,
    input  wire logic ap_rst,
    transposed_folded_fir_hls_div_27s_11s_16_seq_if.slave bus
);
    localparam int c_rw = DIVISOR_WIDTH + 1;
    localparam int c_cw = $clog2(DIVIDEND_WIDTH);
    localparam logic [DIVIDEND_WIDTH-1:0] c_qmax_pos = DIVIDEND_WIDTH'((1 << (QUOTIENT_WIDTH-1)) - 1);
    localparam logic [DIVIDEND_WIDTH-1:0] c_qmax_neg = DIVIDEND_WIDTH'(1 << (QUOTIENT_WIDTH-1));
    localparam logic [QUOTIENT_WIDTH-1:0] c_sat_pos  = {1'b0, {(QUOTIENT_WIDTH-1){1'b1}}};
    localparam logic [QUOTIENT_WIDTH-1:0] c_sat_neg  = {1'b1, {(QUOTIENT_WIDTH-1){1'b0}}};
    localparam logic [c_cw-1:0]           c_last     = c_cw'(DIVIDEND_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                      r_state;
    logic                        r_in_ready;
    logic                        r_out_valid;
    logic                        r_neg_q;
    logic                        r_neg_r;
    logic                        r_zero_dsr;
    logic [DIVIDEND_WIDTH-1:0]   r_dvd;
    logic [DIVISOR_WIDTH-1:0]    r_dsr;
    logic [c_rw-1:0]             r_prem;
    logic [c_cw-1:0]             r_cnt;
    logic [QUOTIENT_WIDTH-1:0]   r_dout;
    logic [DIVISOR_WIDTH-1:0]    r_rem;
    logic                        r_ovf;
    logic                        r_dbz;

    logic [DIVIDEND_WIDTH-1:0]   w_abs0;
    logic [DIVISOR_WIDTH-1:0]    w_abs1;
    logic [c_rw:0]               w_shift;
    logic [c_rw:0]               w_trial;
    logic                        w_fits;
    logic [QUOTIENT_WIDTH-1:0]   w_q_mag;
    logic [QUOTIENT_WIDTH-1:0]   w_q_signed;
    logic [DIVISOR_WIDTH-1:0]    w_r_mag;
    logic [DIVISOR_WIDTH-1:0]    w_r_signed;
    logic                        w_sat;

    // Magnitudes of the most negative operands still fit the unsigned registers.
    assign w_abs0 = bus.din0[DIVIDEND_WIDTH-1] ? (~bus.din0 + DIVIDEND_WIDTH'(1)) : bus.din0;
    assign w_abs1 = bus.din1[DIVISOR_WIDTH-1]  ? (~bus.din1 + DIVISOR_WIDTH'(1))  : bus.din1;

    // One extra bit on the trial difference keeps its sign unambiguous.
    assign w_shift = {r_prem, r_dvd[DIVIDEND_WIDTH-1]};
    assign w_trial = w_shift - {2'b00, r_dsr};
    assign w_fits  = ~w_trial[c_rw];

    // Quotient bits accumulate in r_dvd as the dividend shifts out.
    assign w_q_mag    = r_dvd[QUOTIENT_WIDTH-1:0];
    assign w_q_signed = r_neg_q ? (~w_q_mag + QUOTIENT_WIDTH'(1)) : w_q_mag;
    assign w_sat      = r_neg_q ? (r_dvd > c_qmax_neg) : (r_dvd > c_qmax_pos);
    assign w_r_mag    = r_prem[DIVISOR_WIDTH-1:0];
    assign w_r_signed = r_neg_r ? (~w_r_mag + DIVISOR_WIDTH'(1)) : w_r_mag;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_zero_dsr  <= 1'b0;
            r_dvd       <= '0;
            r_dsr       <= '0;
            r_prem      <= '0;
            r_cnt       <= '0;
            r_dout      <= '0;
            r_rem       <= '0;
            r_ovf       <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (bus.in_valid && r_in_ready) begin
                        r_in_ready <= 1'b0;
                        r_neg_q    <= bus.din0[DIVIDEND_WIDTH-1] ^ bus.din1[DIVISOR_WIDTH-1];
                        r_neg_r    <= bus.din0[DIVIDEND_WIDTH-1];
                        r_dvd      <= w_abs0;
                        r_dsr      <= w_abs1;
                        r_prem     <= '0;
                        r_cnt      <= '0;
                        r_zero_dsr <= (bus.din1 == '0);
                        r_state    <= (bus.din1 == '0) ? S_FIX : S_CALC;
                    end
                end
                S_CALC: begin
                    r_prem  <= w_fits ? w_trial[c_rw-1:0] : w_shift[c_rw-1:0];
                    r_dvd   <= {r_dvd[DIVIDEND_WIDTH-2:0], w_fits};
                    r_cnt   <= r_cnt + c_cw'(1);
                    if (r_cnt == c_last) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_zero_dsr) begin
                        r_dout <= r_neg_r ? c_sat_neg : c_sat_pos;
                        r_rem  <= '0;
                        r_ovf  <= 1'b0;
                        r_dbz  <= 1'b1;
                    end else begin
                        r_dout <= w_sat ? (r_neg_q ? c_sat_neg : c_sat_pos) : w_q_signed;
                        r_rem  <= w_r_signed;
                        r_ovf  <= w_sat;
                        r_dbz  <= 1'b0;
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.dout        = r_dout;
    assign bus.rem         = r_rem;
    assign bus.ovf         = r_ovf;
    assign bus.div_by_zero = r_dbz;
endmodule
`default_nettype wire

// File: tb/tb_transposed_folded_fir_hls_div_27s_11s_16_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_transposed_folded_fir_hls_div_27s_11s_16_seq
// Purpose  : Self-checking bench for the sequential signed divider.
// Revision : 1.0 - initial release
// ============================================================================
module tb_transposed_folded_fir_hls_div_27s_11s_16_seq;
    localparam int DW = 27;
    localparam int VW = 11;
    localparam int QW = 16;

    typedef struct packed {
        logic signed [QW-1:0] q;
        logic signed [VW-1:0] r;
        logic                 ovf;
        logic                 dbz;
    } res_t;

    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];

    always #5 ap_clk = ~ap_clk;

    transposed_folded_fir_hls_div_27s_11s_16_seq_if #(
        .DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW), .QUOTIENT_WIDTH(QW)
    ) bus ();

    transposed_folded_fir_hls_div_27s_11s_16_seq #(
        .DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW), .QUOTIENT_WIDTH(QW)
    ) u_dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    // Reference: integer division truncates toward zero, % follows the dividend.
    function automatic res_t model(input longint a, input longint b);
        res_t   e;
        longint q;
        e = '0;
        if (b == 0) begin
            e.dbz = 1'b1;
            e.q   = (a >= 0) ? 16'h7FFF : 16'h8000;
        end else begin
            q   = a / b;
            e.r = VW'(a % b);
            if (q > 32767) begin
                e.q = 16'h7FFF; e.ovf = 1'b1;
            end else if (q < -32768) begin
                e.q = 16'h8000; e.ovf = 1'b1;
            end else begin
                e.q = QW'(q);
            end
        end
        return e;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output checker: every cycle a result is presented, it must match the model.
    always @(negedge ap_clk) begin
        if (!ap_rst && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                check("dout",        $signed(bus.dout), $signed(exp_q[0].q));
                check("rem",         $signed(bus.rem),  $signed(exp_q[0].r));
                check("ovf",         bus.ovf,           exp_q[0].ovf);
                check("div_by_zero", bus.div_by_zero,   exp_q[0].dbz);
                check("in_ready_busy", bus.in_ready,    0);
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic do_op(input logic signed [DW-1:0] a, input logic signed [VW-1:0] b, input int hold);
        int n;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(posedge ap_clk); #1; n++;
        end
        check("in_ready_wait", bus.in_ready, 1);
        bus.din0     = a;
        bus.din1     = b;
        bus.in_valid = 1'b1;
        exp_q.push_back(model(a, b));
        @(posedge ap_clk); #1;
        bus.in_valid = 1'b0;
        bus.din0     = DW'($urandom);
        bus.din1     = VW'($urandom);
        n = 0;
        while (!bus.out_valid && n < 60) begin
            @(posedge ap_clk); #1; n++;
        end
        check("latency", n, (b == 0) ? 1 : DW + 1);
        repeat (hold) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.din0     = DW'($urandom);
            bus.din1     = VW'($urandom);
            @(posedge ap_clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge ap_clk); #1;
        bus.out_ready = 1'b0;
        check("out_valid_after_take", bus.out_valid, 0);
        check("in_ready_after_take",  bus.in_ready,  1);
    endtask

    longint dir_a [11] = '{1000000, -1000, 1000, -1000, 67108863, -67108864,
                           -67108864, -33554432, 500, -500, 1000000};
    longint dir_b [11] = '{100, 7, -7, -7, 1, -1, -1024, 1024, 0, 0, 100};
    int     dir_h [11] = '{0, 0, 1, 0, 0, 2, 0, 0, 0, 2, 10};

    initial begin
        res_t m;
        logic signed [DW-1:0] ra;
        logic signed [VW-1:0] rb;

        bus.din0 = '0; bus.din1 = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;

        // Hand-computed pins on the reference model itself.
        m = model(1000000, 100);    check("pin_q_1e6_100", m.q, 10000); check("pin_r_1e6_100", m.r, 0);
        m = model(-1000, 7);        check("pin_q_m1000_7", m.q, -142);  check("pin_r_m1000_7", m.r, -6);
        m = model(1000, -7);        check("pin_r_1000_m7", m.r, 6);
        m = model(-1000, -7);       check("pin_q_m1000_m7", m.q, 142);
        m = model(-33554432, 1024); check("pin_q_sat_edge", m.q, -32768); check("pin_ovf_edge", m.ovf, 0);
        m = model(-67108864, -1);   check("pin_q_ovf", m.q, 32767); check("pin_ovf", m.ovf, 1);
        m = model(-500, 0);         check("pin_q_dbz", m.q, -32768); check("pin_dbz", m.dbz, 1);

        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_dout", bus.dout, 0);
        check("rst_rem", bus.rem, 0);
        check("rst_ovf", bus.ovf, 0);
        check("rst_dbz", bus.div_by_zero, 0);
        check("rst_in_ready", bus.in_ready, 0);
        ap_rst = 1'b0;
        @(posedge ap_clk); #1;
        check("in_ready_after_rst", bus.in_ready, 1);

        for (int i = 0; i < 11; i++) begin
            ra = DW'(dir_a[i]);
            rb = VW'(dir_b[i]);
            do_op(ra, rb, dir_h[i]);
        end

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) ra = DW'($urandom);
            else                            ra = DW'($signed(21'($urandom)));
            if ($urandom_range(0, 1) == 0)  rb = VW'($signed(5'($urandom)));
            else                            rb = VW'($urandom);
            do_op(ra, rb, $urandom_range(0, 3));
        end

        // Abort an operation in flight with reset.
        while (!bus.in_ready) begin @(posedge ap_clk); #1; end
        bus.din0 = 27'sd1000000; bus.din1 = 11'sd100; bus.in_valid = 1'b1;
        @(posedge ap_clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) begin @(posedge ap_clk); #1; end
        ap_rst = 1'b1;
        repeat (3) begin
            @(posedge ap_clk); #1;
            check("abort_out_valid", bus.out_valid, 0);
            check("abort_dout", bus.dout, 0);
            check("abort_rem", bus.rem, 0);
            check("abort_in_ready", bus.in_ready, 0);
        end
        ap_rst = 1'b0;
        check("in_ready_before_edge", bus.in_ready, 0);
        @(posedge ap_clk); #1;
        check("in_ready_after_abort", bus.in_ready, 1);
        repeat (30) begin
            @(posedge ap_clk); #1;
            check("no_result_after_abort", bus.out_valid, 0);
        end
        do_op(27'sd84, 11'sd4, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
